cfu_dpram_scratch: RTL
======================

# cfu_dpram_scratch

Parametrised dual-port scratchpad CFU: a generic (vendor-neutral, inferred) true-dual-port RAM behind the standard CFU command/response handshake. Supports single writes, single and paired reads, pointer-based streaming writes, and in-place read-modify-write accumulation. Sits between the CPU's CFU port and nothing else; software uses it as a fast local buffer for kernels. Unlike the previous RAM-test CFU, it honours backpressure on both channels and serialises multi-cycle operations with an FSM.

## Interface
- `ADDR_W`, 10: word-address width; depth = 2^ADDR_W words of 32 bits.
- `ACC_SAT`, 0: 0 = accumulate wraps mod 2^32; 1 = signed saturating accumulate.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_payload_function_id`  in  10  bits [2:0] select the op; bits [9:3] ignored.
- `cmd_payload_inputs_0`  in  32  operand 0; address uses bits [ADDR_W-1:0].
- `cmd_payload_inputs_1`  in  32  operand 1.
- `rsp_valid`  out  1  response present; held until taken.
- `rsp_ready`  in  1  CPU accepts response.
- `rsp_payload_outputs_0`  out  32  response data; stable while `rsp_valid`.

## Operation
- Ops (`function_id[2:0]`), with `a0 = in0[ADDR_W-1:0]` and `a1 = in1[ADDR_W-1:0]`:
  - 0 WRITE: `mem[a0] <= in1`; rsp = 0.
  - 1 READ: rsp = `mem[a0]`.
  - 2 READ_PAIR: port A reads `a0`, port B reads `a1`; rsp = `{memA[15:0], memB[15:0]}`.
  - 3 SET_PTR: `ptr <= a0`; rsp = old `ptr`, zero-extended.
  - 4 STREAM_WR: `mem[ptr] <= in0`; `ptr <= ptr+1`, wrapping 2^ADDR_W-1 to 0; rsp = the `ptr` value used.
  - 5 ACCUM: `mem[a0] <= mem[a0] + in1`; rsp = the new value.
  - 6, 7: no state change; rsp = 0.
- Address bits above ADDR_W are ignored; there is no out-of-range error.
- ACCUM arithmetic:
  - `ACC_SAT=0`: 32-bit two's-complement wrap.
  - `ACC_SAT=1`: signed saturate to 0x7FFFFFFF / 0x80000000.
- FSM states:
  - IDLE: `cmd_ready=1`. On accept, go to RESP for ops 0, 3, 4, 6, 7; go to RD for ops 1, 2, 5.
  - RD: RAM output valid. Ops 1/2 capture rsp and go to RESP. Op 5 computes the sum, writes it back through port A, captures it as rsp, and goes to RESP.
  - RESP: `rsp_valid=1`. On `rsp_ready`, return to IDLE.
- `cmd_ready` is 0 in RD and RESP; exactly one command is outstanding at a time.
- Port B is used only by READ_PAIR, so ports never write the same address simultaneously.
- Reset values:
  - `cmd_ready=0` while `reset` is asserted, then 1 (IDLE).
  - `rsp_valid=0`, `rsp_payload_outputs_0=0`, `ptr=0`, state IDLE.
  - RAM contents are not reset and are undefined after power-up.
- Reset mid-operation aborts the op and drops any pending response. An ACCUM reset while in RD does not write back. A WRITE or STREAM_WR already clocked in at accept stays written.

## Timing
- Accept at edge E (`cmd_valid & cmd_ready`). Writes for ops 0 and 4, the ptr update, and RAM address registration all happen at E.
- Ops 0, 3, 4, 6, 7: `rsp_valid` high in the cycle after E (latency 1).
- Ops 1, 2, 5: `rsp_valid` high two cycles after E (latency 2). The ACCUM write-back lands at edge E+1.
- With `rsp_ready` held high, throughput is one op per 2 cycles (latency-1 ops) or per 3 cycles (latency-2 ops). `rsp_ready` low stalls in RESP indefinitely with the payload held.
- A command arriving while `cmd_ready=0` is not consumed; the CPU keeps `cmd_valid` asserted.
- A READ immediately following a WRITE to the same address returns the new data: the write completes before the read is accepted.

## Test plan
- Reset, WRITE(5, 0xCAFEF00D), READ(5): 0xCAFEF00D returned 2 cycles after accept; `cmd_ready` low during RD/RESP.
- WRITE(3, 0x1111AAAA), WRITE(7, 0x2222BBBB), READ_PAIR(3, 7): rsp = 0xAAAABBBB.
- SET_PTR(2^ADDR_W-1), then STREAM_WR ×3 with 1, 2, 3: rsp = 1023, 0, 1 (ADDR_W=10); READ(1023)=1, READ(0)=2, READ(1)=3.
- ACCUM on a word holding 0x7FFFFFF0, adding 0x20: with `ACC_SAT=0` rsp = 0x80000010; with `ACC_SAT=1` rsp = 0x7FFFFFFF; a following READ matches rsp.
- Hold `rsp_ready=0` for 10 cycles after READ: `rsp_valid` and payload stay stable and `cmd_ready` stays 0; the response completes on the first `rsp_ready=1` cycle.
- Assert `reset` during RD of ACCUM(9, 1) on a word holding 4: `rsp_valid` drops, no response issued, READ(9) afterwards returns 4, `ptr` reads back 0 via SET_PTR.

Source files
------------

// File: rtl/cfu_dpram_scratch_if.sv
// CFU command/response handshake bundle: CPU side is master, scratchpad is slave.
interface cfu_dpram_scratch_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid,
    output cmd_payload_function_id,
    output cmd_payload_inputs_0,
    output cmd_payload_inputs_1,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid,
    input  cmd_payload_function_id,
    input  cmd_payload_inputs_0,
    input  cmd_payload_inputs_1,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_payload_outputs_0
  );
endinterface

// File: rtl/cfu_dpram_scratch.sv
// Dual-port scratchpad CFU: inferred true-dual-port RAM behind a CFU handshake,
// with single/paired reads, pointer streaming writes and read-modify-write accumulate.
module cfu_dpram_scratch #(
  parameter int ADDR_W  = 10,
  parameter bit ACC_SAT = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  cfu_dpram_scratch_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    OP_WRITE     = 3'd0,
    OP_READ      = 3'd1,
    OP_READ_PAIR = 3'd2,
    OP_SET_PTR   = 3'd3,
    OP_STREAM_WR = 3'd4,
    OP_ACCUM     = 3'd5,
    OP_NOP6      = 3'd6,
    OP_NOP7      = 3'd7
  } op_e;

  function automatic logic [31:0] acc_add(input logic signed [31:0] a,
                                          input logic signed [31:0] b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (ACC_SAT && (s[32] != s[31])) begin
      return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    return s[31:0];
  endfunction

  logic [31:0]       mem [DEPTH];

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       addend_q, addend_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       rsp_q, rsp_d;

  logic              we_a;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [31:0]       din_a;
  logic [31:0]       rdata_a_q, rdata_b_q;
  logic [31:0]       acc_sum;

  op_e               op_in;
  logic [ADDR_W-1:0] a0, a1;
  logic              accept;
  logic              unused_fid_bits;

  assign op_in           = op_e'(bus.cmd_payload_function_id[2:0]);
  assign unused_fid_bits = ^bus.cmd_payload_function_id[9:3];
  assign a0              = bus.cmd_payload_inputs_0[ADDR_W-1:0];
  assign a1              = bus.cmd_payload_inputs_1[ADDR_W-1:0];

  assign bus.cmd_ready             = (state_q == S_IDLE) && !reset;
  assign bus.rsp_valid             = (state_q == S_RESP);
  assign bus.rsp_payload_outputs_0 = rsp_q;

  assign accept  = bus.cmd_valid && bus.cmd_ready;
  assign acc_sum = acc_add(rdata_a_q, addend_q);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    addend_d = addend_q;
    ptr_d    = ptr_q;
    rsp_d    = rsp_q;
    we_a     = 1'b0;
    addr_a   = a0;
    din_a    = bus.cmd_payload_inputs_1;
    addr_b   = a1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = op_in;
          addr_d   = a0;
          addend_d = bus.cmd_payload_inputs_1;
          case (op_in)
            OP_WRITE: begin
              we_a    = 1'b1;
              rsp_d   = 32'd0;
              state_d = S_RESP;
            end
            OP_SET_PTR: begin
              ptr_d   = a0;
              rsp_d   = 32'(ptr_q);
              state_d = S_RESP;
            end
            OP_STREAM_WR: begin
              addr_a  = ptr_q;
              din_a   = bus.cmd_payload_inputs_0;
              we_a    = 1'b1;
              ptr_d   = ptr_q + ADDR_W'(1);
              rsp_d   = 32'(ptr_q);
              state_d = S_RESP;
            end
            OP_READ, OP_READ_PAIR, OP_ACCUM: begin
              state_d = S_RD;
            end
            default: begin
              rsp_d   = 32'd0;
              state_d = S_RESP;
            end
          endcase
        end
      end

      // RAM data registered at accept is valid here; accumulate writes back via port A.
      S_RD: begin
        case (op_q)
          OP_READ:      rsp_d = rdata_a_q;
          OP_READ_PAIR: rsp_d = {rdata_a_q[15:0], rdata_b_q[15:0]};
          OP_ACCUM: begin
            addr_a = addr_q;
            din_a  = acc_sum;
            we_a   = 1'b1;
            rsp_d  = acc_sum;
          end
          default:      rsp_d = 32'd0;
        endcase
        state_d = S_RESP;
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rsp_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rsp_q   <= rsp_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q     <= op_d;
    addr_q   <= addr_d;
    addend_q <= addend_d;
  end

  // Port A: read-first, sole writer. Port B: read-only, used by paired reads.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= din_a;
    end
    rdata_a_q <= mem[addr_a];
  end

  always_ff @(posedge clk) begin
    rdata_b_q <= mem[addr_b];
  end

endmodule
